// File: rtl/sr_drv_pkg.sv
// Shared types for the SR latch command driver: FSM states and command encoding.
package sr_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CMD_NONE = 2'b00,
      CMD_SET  = 2'b01,
      CMD_CLR  = 2'b10
   } cmd_t;

   // Simultaneous set and clear edges are ambiguous and produce no command.
   function automatic cmd_t arbitrate(input logic set_rise, input logic clr_rise);
      cmd_t c;
      c = CMD_NONE;
      if (set_rise && !clr_rise) c = CMD_SET;
      if (clr_rise && !set_rise) c = CMD_CLR;
      return c;
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser, stability counter and single-cycle rising-edge pulse for one request line.
module sr_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_i,
   output logic rise_o
);

   logic             meta_q, sync_q;
   logic             filt_q, filt_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Filtered level follows the synchronised level only after it has differed long enough.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      rise_d = 1'b0;
      if (sync_q != filt_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_d = sync_q;
            rise_d = sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchroniser and debounce state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         filt_q <= 1'b0;
         rise_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         meta_q <= req_i;
         sync_q <= meta_q;
         filt_q <= filt_d;
         rise_q <= rise_d;
         cnt_q  <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Turns debounced set/clear requests into well-formed gated SR latch writes (setup, EN pulse, hold).
module sr_latch_driver
   import sr_drv_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned EN_PULSE        = 2,
   parameter int unsigned CNT_W           = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_req,
   input  logic clr_req,
   output logic S,
   output logic R,
   output logic EN,
   output logic busy,
   output logic q_model,
   output logic conflict
);

   logic set_rise, clr_rise;

   cmd_t             cmd_q, cmd_d;
   logic             conflict_q, conflict_d;
   state_t           state_q, state_d;
   cmd_t             cur_q, cur_d;
   cmd_t             slot_q, slot_d;
   cmd_t             pending;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic             qm_q, qm_d;
   logic             s_q, s_d, r_q, r_d, en_q, en_d, busy_q, busy_d;

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_set (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (set_req),
      .rise_o (set_rise)
   );

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clr (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (clr_req),
      .rise_o (clr_rise)
   );

   // Edge arbitration into a one-cycle command strobe; conflicts latch until reset.
   always_comb begin
      cmd_d      = arbitrate(set_rise, clr_rise);
      conflict_d = conflict_q | (set_rise & clr_rise);
   end

   // Write sequencer: next state, pending slot, pulse counter, model and registered latch drives.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      slot_d  = slot_q;
      pcnt_d  = pcnt_q;
      qm_d    = qm_q;
      pending = (cmd_q != CMD_NONE) ? cmd_q : slot_q;

      if (state_q != IDLE && cmd_q != CMD_NONE) slot_d = cmd_q;

      case (state_q)
         IDLE: begin
            if (cmd_q != CMD_NONE) begin
               state_d = SETUP;
               cur_d   = cmd_q;
            end
         end
         SETUP: begin
            state_d = PULSE;
            pcnt_d  = '0;
         end
         PULSE: begin
            if (pcnt_q == CNT_W'(EN_PULSE - 1)) state_d = HOLD;
            else                                pcnt_d  = pcnt_q + CNT_W'(1);
         end
         HOLD: begin
            qm_d   = (cur_q == CMD_SET);
            slot_d = CMD_NONE;
            if (pending != CMD_NONE) begin
               state_d = SETUP;
               cur_d   = pending;
            end else begin
               state_d = IDLE;
               cur_d   = CMD_NONE;
            end
         end
         default: state_d = IDLE;
      endcase

      s_d    = (state_d != IDLE) && (cur_d == CMD_SET);
      r_d    = (state_d != IDLE) && (cur_d == CMD_CLR);
      en_d   = (state_d == PULSE);
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_q      <= CMD_NONE;
         conflict_q <= 1'b0;
         state_q    <= IDLE;
         cur_q      <= CMD_NONE;
         slot_q     <= CMD_NONE;
         pcnt_q     <= '0;
         qm_q       <= 1'b0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         cmd_q      <= cmd_d;
         conflict_q <= conflict_d;
         state_q    <= state_d;
         cur_q      <= cur_d;
         slot_q     <= slot_d;
         pcnt_q     <= pcnt_d;
         qm_q       <= qm_d;
         s_q        <= s_d;
         r_q        <= r_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
      end
   end

   assign S        = s_q;
   assign R        = r_q;
   assign EN       = en_q;
   assign busy     = busy_q;
   assign q_model  = qm_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a scoreboard of expected latch writes.
module tb_sr_latch_driver;

   logic clk = 1'b0;
   logic rst_n, set_req, clr_req;
   logic S, R, EN, busy, q_model, conflict;

   int total = 0;
   int bad   = 0;

   logic [1:0] exp_sr[$];
   logic       exp_q[$];

   sr_latch_driver dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_req  (set_req),
      .clr_req  (clr_req),
      .S        (S),
      .R        (R),
      .EN       (EN),
      .busy     (busy),
      .q_model  (q_model),
      .conflict (conflict)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic push_exp(input logic [1:0] sr, input logic q);
      exp_sr.push_back(sr);
      exp_q.push_back(q);
   endtask

   // Monitor: invariants every cycle, and each completed write (EN falls into HOLD) against the scoreboard.
   initial begin : monitor
      logic       en_prev, s_prev, r_prev, qchk, q_want;
      logic [1:0] sr_want;
      int         en_cnt;
      en_prev = 1'b0; s_prev = 1'b0; r_prev = 1'b0; qchk = 1'b0; q_want = 1'b0;
      en_cnt  = 0;
      forever begin
         @(negedge clk);
         check("s_and_r", int'(S & R), 0);
         if (en_prev && EN) check("sr_stable_while_en", int'({S, R}), int'({s_prev, r_prev}));
         if (qchk) begin
            qchk = 1'b0;
            check("q_model_after_write", int'(q_model), int'(q_want));
         end
         if (EN) begin
            en_cnt++;
         end else if (en_prev) begin
            if (busy) begin
               if (exp_sr.size() == 0) begin
                  check("unexpected_write", 1, 0);
               end else begin
                  sr_want = exp_sr.pop_front();
                  q_want  = exp_q.pop_front();
                  check("write_sr", int'({S, R}), int'(sr_want));
                  check("en_width", en_cnt, 2);
                  qchk = 1'b1;
               end
            end
            en_cnt = 0;
         end
         en_prev = EN; s_prev = S; r_prev = R;
      end
   end

   initial begin : stim
      int first_s, act, run, max_run;
      rst_n = 1'b0; set_req = 1'b0; clr_req = 1'b0;
      ticks(3);
      check("rst_S", int'(S), 0);
      check("rst_R", int'(R), 0);
      check("rst_EN", int'(EN), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_q_model", int'(q_model), 0);
      check("rst_conflict", int'(conflict), 0);

      // 1: set held from release; S after edge 7, q_model after edge 11
      push_exp(2'b10, 1'b1);
      rst_n = 1'b1; set_req = 1'b1;
      first_s = -1;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (S && first_s < 0) first_s = k;
         if (k == 11) begin
            check("t1_q_model", int'(q_model), 1);
            check("t1_busy_idle", int'(busy), 0);
         end
      end
      check("t1_s_latency", first_s, 7);

      // 2: 3-cycle glitch on clr is filtered
      clr_req = 1'b1;
      ticks(3);
      clr_req = 1'b0;
      act = 0;
      for (int k = 0; k < 18; k++) begin
         tick();
         if (S || R || EN) act = 1;
      end
      check("t2_no_activity", act, 0);
      check("t2_q_model", int'(q_model), 1);

      // 3: simultaneous rise gives conflict and no command
      set_req = 1'b0;
      ticks(12);
      set_req = 1'b1; clr_req = 1'b1;
      act = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (S || R || EN) act = 1;
      end
      check("t3_no_activity", act, 0);
      check("t3_conflict", int'(conflict), 1);

      // 4: clear arrives during a set write; slot runs it straight after HOLD; then a final set
      set_req = 1'b0; clr_req = 1'b0;
      ticks(12);
      push_exp(2'b10, 1'b1);
      push_exp(2'b01, 1'b0);
      set_req = 1'b1;
      ticks(2);
      clr_req = 1'b1;
      run = 0; max_run = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         run = busy ? run + 1 : 0;
         if (run > max_run) max_run = run;
      end
      check("t4_back_to_back_busy", max_run, 8);
      set_req = 1'b0;
      ticks(12);
      push_exp(2'b10, 1'b1);
      set_req = 1'b1;
      ticks(15);
      check("t4_q_model", int'(q_model), 1);
      check("t4_conflict_sticky", int'(conflict), 1);

      // 5: reset during PULSE aborts the write without updating q_model
      set_req = 1'b0; clr_req = 1'b0;
      ticks(12);
      push_exp(2'b01, 1'b0);
      clr_req = 1'b1;
      ticks(15);
      set_req = 1'b1;
      ticks(9);
      check("t5_in_pulse", int'({S, EN, busy}), 7);
      rst_n = 1'b0; set_req = 1'b0; clr_req = 1'b0;
      tick();
      check("t5_abort_outputs", int'({S, R, EN, busy}), 0);
      check("t5_q_model", int'(q_model), 0);
      check("t5_conflict_cleared", int'(conflict), 0);
      rst_n = 1'b1;
      act = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (S || R || EN || busy) act = 1;
      end
      check("t5_quiet_after_reset", act, 0);

      ticks(3);
      check("scoreboard_drained", exp_sr.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
